// File: rtl/rho_rotate_stage_pkg.sv
// Shared constants for the Keccak rho stage: FSM encoding,
// lane geometry and the per-lane rotation offsets.
package rho_rotate_stage_pkg;

    localparam int LANE_LEN = 64;
    localparam int SLICE_W  = 25;
    localparam int CNT_W    = 6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_ROTATE = 3'd2;
    localparam logic [2:0] ST_INFORM = 3'd3;
    localparam logic [2:0] ST_OUTPUT = 3'd4;

    localparam logic [CNT_W-1:0] SLICE_LAST = 6'd63;
    // Largest offset is 62, so the rotate phase runs rotCnt 0..61.
    localparam logic [CNT_W-1:0] ROT_LAST   = 6'd61;

    // Indexed by lane i = 5*y + x.
    localparam logic [CNT_W-1:0] RHO_OFFSET [SLICE_W] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

endpackage

// File: rtl/rho_rotate_stage_controller.sv
// Sequencing FSM for the rho stage: load, rotate, inform,
// stream out; counters live in the datapath.
module rho_rotate_stage_controller
    import rho_rotate_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inReady,
    input  logic sliceLast,
    input  logic rotLast,
    output logic ldEn,
    output logic rotEn,
    output logic outEn,
    output logic cntClr,
    output logic ready,
    output logic outReady
);

    logic [2:0] state;
    logic [2:0] stateNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntClr    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (inReady) begin
                    stateNext = ST_LOAD;
                    cntClr    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (sliceLast) begin
                    stateNext = ST_ROTATE;
                    cntClr    = 1'b1;
                end
            end
            ST_ROTATE: begin
                if (rotLast) begin
                    stateNext = ST_INFORM;
                end
            end
            ST_INFORM: begin
                stateNext = ST_OUTPUT;
                cntClr    = 1'b1;
            end
            ST_OUTPUT: begin
                if (sliceLast) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    assign ready    = (state == ST_IDLE);
    assign ldEn     = (state == ST_LOAD);
    assign rotEn    = (state == ST_ROTATE);
    assign outReady = (state == ST_INFORM);
    assign outEn    = (state == ST_OUTPUT);

endmodule

// File: rtl/rho_rotate_stage.sv
// Keccak rho step: capture 64 slices, rotate every lane by its
// fixed offset one bit per cycle, then stream slices back out.
module rho_rotate_stage
    import rho_rotate_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inReady,
    input  logic [SLICE_W-1:0] sliceIn,
    output logic               ready,
    output logic               outReady,
    output logic [SLICE_W-1:0] sliceOut
);

    logic [CNT_W-1:0]    sliceCnt;
    logic [CNT_W-1:0]    rotCnt;
    logic                ldEn;
    logic                rotEn;
    logic                outEn;
    logic                cntClr;
    logic                sliceLast;
    logic                rotLast;
    logic [LANE_LEN-1:0] lane [SLICE_W];

    assign sliceLast = (sliceCnt == SLICE_LAST);
    assign rotLast   = (rotCnt == ROT_LAST);

    rho_rotate_stage_controller u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .inReady  (inReady),
        .sliceLast(sliceLast),
        .rotLast  (rotLast),
        .ldEn     (ldEn),
        .rotEn    (rotEn),
        .outEn    (outEn),
        .cntClr   (cntClr),
        .ready    (ready),
        .outReady (outReady)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sliceCnt <= '0;
            rotCnt   <= '0;
        end else if (cntClr) begin
            sliceCnt <= '0;
            rotCnt   <= '0;
        end else begin
            if (ldEn || outEn) begin
                sliceCnt <= sliceCnt + 1'b1;
            end
            if (rotEn) begin
                rotCnt <= rotCnt + 1'b1;
            end
        end
    end

    // A lane stops shifting once rotCnt reaches its offset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLICE_W; i++) begin
            if (ldEn) begin
                lane[i][sliceCnt] <= sliceIn[i];
            end else if (rotEn && (rotCnt < RHO_OFFSET[i])) begin
                lane[i] <= {lane[i][LANE_LEN-2:0], lane[i][LANE_LEN-1]};
            end
        end
    end

    always_comb begin
        sliceOut = '0;
        if (outEn) begin
            for (int i = 0; i < SLICE_W; i++) begin
                sliceOut[i] = lane[i][sliceCnt];
            end
        end
    end

endmodule
